boolfuck_byte_io: RTL and testbench

Byte-stream I/O bridge for the boolfuck interpreter core. It runs the opposite way to the interpreter's bit-level I/O. Output bits produced by the core are packed LSB-first into bytes and queued to a byte sink. Bytes from a byte source are unpacked LSB-first and handed back to the core one bit per input operation. It sits between the interpreter and any UART, host FIFO or testbench byte channel.

---
 rtl/boolfuck_byte_io.sv | 77 +++++++
 tb/tb_boolfuck_byte_io.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/boolfuck_byte_io.sv
// boolfuck_byte_io: packs core output bits LSB-first into a byte FIFO and unpacks input bytes LSB-first into core bits.
// Optional BFIO_EOF_ZERO_EN: an exhausted byte source feeds endless zero bits instead of stalling the core.
module boolfuck_byte_io #(
  parameter int D = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bo_valid,
  input  logic       bo_bit,
  output logic       bo_ready,
  input  logic       flush,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       rx_eof,
  output logic       bi_valid,
  output logic       bi_bit,
  input  logic       bi_ready,
  output logic [2:0] obits,
  output logic [3:0] ibits
);
  localparam int N = 1 << D;
  logic [7:0] mem [N];
  logic [D:0] wptr, rptr;
  logic [7:0] obuf, ibuf, push_data;
  logic       flush_pend, full, tx_pop, acc, push_bit, flush_go, push;
  assign full      = (wptr[D] != rptr[D]) && (wptr[D-1:0] == rptr[D-1:0]);
  assign tx_valid  = wptr != rptr;
  assign tx_data   = tx_valid ? mem[rptr[D-1:0]] : 8'h00;
  assign tx_pop    = tx_valid && tx_ready;
  assign bo_ready  = !flush_pend && (obits != 3'd7 || !full || tx_pop);
  assign acc       = bo_valid && bo_ready;
  assign push_bit  = acc && obits == 3'd7;
  assign flush_go  = flush_pend && obits != 3'd0 && (!full || tx_pop);
  assign push      = push_bit || flush_go;
  // stale bits above obits are masked off for a padded flush byte
  assign push_data = push_bit ? {bo_bit, obuf[6:0]} : obuf & ((8'd1 << obits) - 8'd1);
  assign rx_ready  = ibits == 4'd0;
  assign bi_bit    = ibits != 4'd0 && ibuf[0];
`ifdef BFIO_EOF_ZERO_EN
  assign bi_valid  = ibits != 4'd0 || (!rx_valid && rx_eof);
`else
  logic unused_eof;
  assign bi_valid  = ibits != 4'd0;
  assign unused_eof = rx_eof;
`endif
  always_ff @(posedge clk)
    if (push) mem[wptr[D-1:0]] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      obuf       <= '0;
      obits      <= '0;
      flush_pend <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      ibuf       <= '0;
      ibits      <= '0;
    end else begin
      if (acc) begin
        obuf[obits] <= bo_bit;
        obits       <= obits + 3'd1;
      end else if (flush_go) obits <= 3'd0;
      flush_pend <= flush || (flush_pend && !flush_go && obits != 3'd0);
      if (push) wptr <= wptr + {{D{1'b0}}, 1'b1};
      if (tx_pop) rptr <= rptr + {{D{1'b0}}, 1'b1};
      if (rx_valid && rx_ready) begin
        ibuf  <= rx_data;
        ibits <= 4'd8;
      end else if (ibits != 4'd0 && bi_ready) begin
        ibuf  <= ibuf >> 1;
        ibits <= ibits - 4'd1;
      end
    end
endmodule

// File: tb/tb_boolfuck_byte_io.sv
// tb_boolfuck_byte_io: table-driven cycle vectors plus directed FIFO-full, reset and EOF sequences.
module tb_boolfuck_byte_io;
  logic clk = 0, rst_n = 1;
  logic bo_valid = 0, bo_bit = 0, flush = 0, tx_ready = 0, rx_valid = 0, rx_eof = 0, bi_ready = 0;
  logic [7:0] rx_data = 0;
  logic bo_ready, tx_valid, rx_ready, bi_valid, bi_bit;
  logic [7:0] tx_data;
  logic [2:0] obits;
  logic [3:0] ibits;
  int checks = 0, errors = 0;
`ifdef BFIO_EOF_ZERO_EN
  localparam bit EOF_EN = 1'b1;
`else
  localparam bit EOF_EN = 1'b0;
`endif
  boolfuck_byte_io #(.D(2)) dut (
    .clk(clk), .rst_n(rst_n), .bo_valid(bo_valid), .bo_bit(bo_bit), .bo_ready(bo_ready),
    .flush(flush), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_eof(rx_eof),
    .bi_valid(bi_valid), .bi_bit(bi_bit), .bi_ready(bi_ready), .obits(obits), .ibits(ibits)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic bv, bb, fl, tr, rv;
    logic [7:0] rd;
    logic br, e_bor, e_txv;
    logic [7:0] e_txd;
    logic [2:0] e_ob;
    logic e_rxr, e_biv, e_bib;
    logic [3:0] e_ib;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic bv, bb, fl, tr, rv, input logic [7:0] rd, input logic br,
                     input logic e_bor, e_txv, input logic [7:0] e_txd, input logic [2:0] e_ob,
                     input logic e_rxr, e_biv, e_bib, input logic [3:0] e_ib);
    vec_t v;
    v = '{bv, bb, fl, tr, rv, rd, br, e_bor, e_txv, e_txd, e_ob, e_rxr, e_biv, e_bib, e_ib};
    tbl.push_back(v);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, " bo_ready"}, bo_ready, 1);
    chk({tag, " tx_valid"}, tx_valid, 0);
    chk({tag, " tx_data"}, tx_data, 0);
    chk({tag, " rx_ready"}, rx_ready, 1);
    chk({tag, " bi_valid"}, bi_valid, 0);
    chk({tag, " bi_bit"}, bi_bit, 0);
    chk({tag, " obits"}, obits, 0);
    chk({tag, " ibits"}, ibits, 0);
  endtask
  initial begin
    logic [7:0] out_bits, a3, fifo_bytes [5];
    out_bits = 8'h65;
    a3 = 8'hA3;
    fifo_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 8; i++)
      add(1, out_bits[i], 0, 1, 0, 0, 0, 1, 0, 0, 3'(i), 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1, 8'h65, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 8'hA3, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 0, 1, 8'h5C, 1, 1, 0, 0, 0, 0, 1, a3[i], 4'(8 - i));
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3'(i), 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h07, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1, 8'h07, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    #1 rst_n = 0;
    #1 chk_reset_vals("init");
    @(negedge clk) rst_n = 1;
    step();
    foreach (tbl[i]) begin
      {bo_valid, bo_bit, flush, tx_ready, rx_valid, rx_data, bi_ready} =
        {tbl[i].bv, tbl[i].bb, tbl[i].fl, tbl[i].tr, tbl[i].rv, tbl[i].rd, tbl[i].br};
      @(negedge clk);
      chk($sformatf("row%0d bo_ready", i), bo_ready, tbl[i].e_bor);
      chk($sformatf("row%0d tx_valid", i), tx_valid, tbl[i].e_txv);
      chk($sformatf("row%0d tx_data", i), tx_data, tbl[i].e_txd);
      chk($sformatf("row%0d obits", i), obits, tbl[i].e_ob);
      chk($sformatf("row%0d rx_ready", i), rx_ready, tbl[i].e_rxr);
      chk($sformatf("row%0d bi_valid", i), bi_valid, tbl[i].e_biv);
      chk($sformatf("row%0d bi_bit", i), bi_bit, tbl[i].e_bib);
      chk($sformatf("row%0d ibits", i), ibits, tbl[i].e_ib);
      step();
    end
    {bo_valid, flush, tx_ready, rx_valid, bi_ready} = '0;
    // four full bytes fill the FIFO, then seven bits of a fifth byte
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < (k == 4 ? 7 : 8); j++) begin
        bo_valid = 1;
        bo_bit = fifo_bytes[k][j];
        @(negedge clk) chk($sformatf("fill b%0d.%0d bo_ready", k, j), bo_ready, 1);
        step();
      end
    bo_bit = fifo_bytes[4][7];
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("full bo_ready", bo_ready, 0);
      chk("full obits", obits, 7);
      chk("full head", tx_data, 8'h11);
      step();
    end
    tx_ready = 1;
    @(negedge clk) chk("pop+push bo_ready", bo_ready, 1);
    step();
    bo_valid = 0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d tx_valid", k), tx_valid, 1);
      chk($sformatf("drain%0d tx_data", k), tx_data, fifo_bytes[k]);
      step();
    end
    @(negedge clk);
    chk("drained tx_valid", tx_valid, 0);
    chk("drained obits", obits, 0);
    tx_ready = 0;
    step();
    for (int j = 0; j < 21; j++) begin
      bo_valid = 1;
      bo_bit = j[0];
      step();
    end
    bo_valid = 0;
    rx_valid = 1;
    rx_data = 8'hF0;
    step();
    rx_valid = 0;
    bi_ready = 1;
    repeat (5) step();
    bi_ready = 0;
    @(negedge clk);
    chk("pre-reset obits", obits, 5);
    chk("pre-reset ibits", ibits, 3);
    chk("pre-reset tx_valid", tx_valid, 1);
    #1 rst_n = 0;
    #1 chk_reset_vals("async");
    #1 rst_n = 1;
    step();
    rx_eof = 1;
    bi_ready = 1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("eof bi_valid", bi_valid, EOF_EN);
      chk("eof bi_bit", bi_bit, 0);
      chk("eof ibits", ibits, 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
